mem_port_arbiter: RTL and testbench

Parametrised successor to the single-requester memory accesser. It arbitrates `NUM_PORTS` independent requesters (instruction fetch, load/store, future DMA) onto the one byte-serial RAM bus, and serialises 1/2/4-byte reads and writes. It sits between the core-side memory clients and the top-level RAM pins (`mem_din`/`mem_dout`/`mem_a`/`mem_wr`).

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one byte-serial RAM bus; MEMARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
// Latency: ack 1 cycle after acceptance; write done at E+n+1, read done with rdata at E+n+2.
// Backpressure: rdy low freezes all state and masks mem_wr; losing requesters must hold req until ack.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          clr,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [2*NUM_PORTS-1:0]        width,
    input  logic [ADDR_W*NUM_PORTS-1:0]   addr,
    input  logic [32*NUM_PORTS-1:0]       wdata,
    output logic [NUM_PORTS-1:0]          ack,
    output logic [NUM_PORTS-1:0]          done,
    output logic [32*NUM_PORTS-1:0]       rdata,
    input  logic [7:0]                    mem_din,
    output logic [7:0]                    mem_dout,
    output logic [ADDR_W-1:0]             mem_a,
    output logic                          mem_wr
);
    localparam int N  = NUM_PORTS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        n_q;
    logic [PW-1:0]     cur;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf;
    logic [31:0]       rbuf_nxt;
    logic              mem_wr_q;
    logic              gnt_vld;
    logic [PW-1:0]     gnt;
    logic [1:0]        nb;

    function automatic logic [2:0] len_of(input logic [1:0] w);
        case (w)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

`ifdef MEMARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_vld = 1'b1;
                gnt     = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] last;

    // Descending scan so the port closest after 'last' is the final assignment.
    always_comb begin : rr
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt     = PW'(idx);
            end
        end
    end
`endif

    // Byte arriving now belongs to the address driven in the previous cycle.
    always_comb begin
        rbuf_nxt = rbuf;
        if (cnt != 3'd0)
            rbuf_nxt[{cnt - 3'd1, 3'b000} +: 8] = mem_din;
    end

    assign nb     = cnt[1:0] + 2'd1;
    assign mem_wr = mem_wr_q & rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            n_q      <= 3'd1;
            cur      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf     <= '0;
            ack      <= '0;
            done     <= '0;
            rdata    <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr_q <= 1'b0;
`ifndef MEMARB_FIXED_PRIO_EN
            last     <= PW'(N - 1);
`endif
        end else if (rdy) begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
`ifndef MEMARB_FIXED_PRIO_EN
                        last <= gnt;
`endif
                        cur      <= gnt;
                        cnt      <= '0;
                        ack[gnt] <= 1'b1;
                        addr_q   <= addr[int'(gnt)*ADDR_W +: ADDR_W];
                        wdata_q  <= wdata[int'(gnt)*32 +: 32];
                        n_q      <= len_of(width[int'(gnt)*2 +: 2]);
                        rbuf     <= '0;
                        mem_a    <= addr[int'(gnt)*ADDR_W +: ADDR_W];
                        mem_wr_q <= we[gnt];
                        if (we[gnt]) begin
                            mem_dout <= wdata[int'(gnt)*32 +: 8];
                            state    <= WR;
                        end else begin
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    if (cnt == n_q - 3'd1) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        done[cur] <= 1'b1;
                        mem_a     <= '0;
                        mem_wr_q  <= 1'b0;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        mem_a    <= addr_q + ADDR_W'(cnt + 3'd1);
                        mem_dout <= wdata_q[{nb, 3'b000} +: 8];
                    end
                end
                RD: begin
                    if (clr) begin
                        state <= IDLE;
                        cnt   <= '0;
                        mem_a <= '0;
                    end else if (cnt == n_q) begin
                        state                    <= IDLE;
                        cnt                      <= '0;
                        done[cur]                <= 1'b1;
                        rdata[int'(cur)*32 +: 32] <= rbuf_nxt;
                        mem_a                    <= '0;
                    end else begin
                        cnt  <= cnt + 3'd1;
                        rbuf <= rbuf_nxt;
                        // Past the last byte the address holds while the final byte returns.
                        if (cnt + 3'd1 < n_q)
                            mem_a <= addr_q + ADDR_W'(cnt + 3'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of mem_port_arbiter: writes, reads, abort, stall, arbitration order, async reset.
module tb_mem_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst, rdy, clr;
    logic [N-1:0]      req, we, ack, done;
    logic [2*N-1:0]    width;
    logic [AW*N-1:0]   addr;
    logic [32*N-1:0]   wdata, rdata;
    logic [7:0]        mem_din = 8'h00;
    logic [7:0]        mem_dout;
    logic [AW-1:0]     mem_a;
    logic              mem_wr;

    logic [7:0]        ram [256];
    logic [39:0]       wlog [$];
    int                grants [$];
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                cyc_acc;
    logic [N-1:0]      seen_done;
    logic [31:0]       wd1 = 32'hA1B2C3D4;
    logic [31:0]       wd4 = 32'h11223344;
`ifdef MEMARB_FIXED_PRIO_EN
    int                exp_order [6] = '{0, 0, 0, 0, 0, 0};
`else
    int                exp_order [6] = '{0, 1, 2, 0, 1, 2};
`endif

    mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .req(req), .we(we), .width(width), .addr(addr), .wdata(wdata),
        .ack(ack), .done(done), .rdata(rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM plus a log of committed write beats.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[7:0]];
        if (mem_wr) wlog.push_back({mem_a, mem_dout});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_port(input int p, input logic w, input logic [1:0] wid,
                            input logic [31:0] a, input logic [31:0] d);
        we[p]            = w;
        width[p*2 +: 2]  = wid;
        addr[p*AW +: AW] = a;
        wdata[p*32 +: 32] = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h20] = 8'h34; ram[8'h21] = 8'h12;
        ram[8'h50] = 8'h5A; ram[8'h60] = 8'h66;
        ram[8'h40] = 8'hC0; ram[8'h41] = 8'hC1; ram[8'h42] = 8'hC2; ram[8'h43] = 8'hC3;
        rst = 1'b0; rdy = 1'b1; clr = 1'b0;
        req = '0; we = '0; width = '0; addr = '0; wdata = '0;

        #12;
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata[63:0], 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        rst = 1'b1;
        step();

        // Word write on port 1
        set_port(1, 1'b1, 2'b10, 32'h100, wd1);
        req = 3'b010;
        step();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_ack", ack, (i == 0) ? 64'h2 : 64'h0);
            chk("wr_mem_wr", mem_wr, 1);
            chk("wr_mem_a", mem_a, 64'h100 + i);
            chk("wr_mem_dout", mem_dout, wd1[8*i +: 8]);
            chk("wr_done_early", done, 0);
            step();
        end
        chk("wr_done", done, 3'b010);
        chk("wr_idle_mem_wr", mem_wr, 0);
        chk("wr_idle_mem_a", mem_a, 0);
        chk("wr_idle_dout_hold", mem_dout, 8'hA1);
        step();
        chk("wr_done_pulse", done, 0);

        // Half read on port 0
        set_port(0, 1'b0, 2'b01, 32'h20, 32'h0);
        req = 3'b001;
        step();
        req = '0;
        chk("hr_ack", ack, 3'b001);
        chk("hr_a0", mem_a, 32'h20);
        chk("hr_wr", mem_wr, 0);
        step();
        chk("hr_a1", mem_a, 32'h21);
        step();
        chk("hr_a_hold", mem_a, 32'h21);
        chk("hr_done_early", done, 0);
        step();
        chk("hr_done", done, 3'b001);
        chk("hr_rdata", rdata[31:0], 32'h00001234);

        // Byte read on port 2 to give it a known previous value
        set_port(2, 1'b0, 2'b00, 32'h50, 32'h0);
        req = 3'b100;
        step();
        req = '0;
        chk("br_ack", ack, 3'b100);
        step(); step();
        chk("br_done", done, 3'b100);
        chk("br_rdata", rdata[95:64], 32'h0000005A);

        // Word read on port 2 aborted with clr; port 0 pending
        set_port(2, 1'b0, 2'b10, 32'h40, 32'h0);
        req = 3'b100;
        step();
        chk("ab_ack", ack, 3'b100);
        set_port(0, 1'b0, 2'b00, 32'h60, 32'h0);
        req = 3'b001;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ab_no_done", done, 0);
        chk("ab_idle_mem_a", mem_a, 0);
        chk("ab_rdata_kept", rdata[95:64], 32'h0000005A);
        step();
        req = '0;
        chk("ab_next_ack", ack, 3'b001);
        chk("ab_next_a", mem_a, 32'h60);
        step(); step();
        chk("ab_next_done", done, 3'b001);
        chk("ab_next_rdata", rdata[31:0], 32'h00000066);
        chk("ab_rdata2_still", rdata[95:64], 32'h0000005A);

        // Word write on port 1 with a 3-cycle stall
        wlog.delete();
        set_port(1, 1'b1, 2'b10, 32'h200, wd4);
        req = 3'b010;
        step();
        cyc_acc = cyc - 1;
        req = '0;
        chk("st_a0", mem_a, 32'h200);
        step();
        chk("st_a1", mem_a, 32'h201);
        rdy = 1'b0;
        #1;
        chk("st_wr_masked", mem_wr, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_a", mem_a, 32'h201);
            chk("st_hold_wr", mem_wr, 0);
            chk("st_hold_dout", mem_dout, 8'h33);
        end
        rdy = 1'b1;
        for (int i = 0; i < 20 && done == 0; i++) step();
        chk("st_done", done, 3'b010);
        chk("st_done_delay", cyc - cyc_acc, 8);
        chk("st_nbeats", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk($sformatf("st_beat%0d", i), wlog[i], {32'h200 + i, wd4[8*i +: 8]});

        // Simultaneous byte reads from reset
        rst = 1'b0;
        req = 3'b111;
        set_port(0, 1'b0, 2'b00, 32'h70, 32'h0);
        set_port(1, 1'b0, 2'b00, 32'h71, 32'h0);
        set_port(2, 1'b0, 2'b00, 32'h72, 32'h0);
        #3;
        rst = 1'b1;
        for (int c = 0; c < 40 && grants.size() < 6; c++) begin
            step();
            chk("sim_ack_done_overlap", ack & done, 0);
            if (ack != 0)
                grants.push_back(ack == 3'b001 ? 0 : ack == 3'b010 ? 1 : ack == 3'b100 ? 2 : 9);
        end
        chk("sim_grant_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("sim_grant%0d", i), grants[i], exp_order[i]);
        req = '0;
        for (int i = 0; i < 6; i++) step();

        // Reset in the middle of a word read
        set_port(0, 1'b0, 2'b10, 32'h40, 32'h0);
        req = 3'b001;
        step();
        req = '0;
        chk("rr_ack", ack, 3'b001);
        step();
        chk("rr_mid_a", mem_a, 32'h41);
        #1;
        rst = 1'b0;
        #1;
        chk("rr_mem_a", mem_a, 0);
        chk("rr_ack0", ack, 0);
        chk("rr_done0", done, 0);
        chk("rr_rdata", rdata, 0);
        chk("rr_mem_wr", mem_wr, 0);
        chk("rr_mem_dout", mem_dout, 0);
        #2;
        rst = 1'b1;
        seen_done = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen_done = seen_done | done;
        end
        chk("rr_no_done", seen_done, 0);
        chk("rr_idle_a", mem_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
